csr_irq_trap_unit: RTL and testbench

- Parametrised machine-mode CSR file and interrupt/trap controller for the pCPU RV32 core.
- Supports NUM_EXT external interrupt channels, the timer interrupt and the software interrupt, with fixed-priority arbitration.
- Provides write/set/clear CSR ops, synchronous exception entry, handshaked interrupt entry, mret, direct/vectored mtvec, and per-channel acknowledge pulses back to the sources.
- Sits between the CPU execute stage and the interrupt/timer peripherals.

---
 rtl/csr_irq_trap_unit.sv | 174 +++++++++++++++++
 tb/tb_csr_irq_trap_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_irq_trap_unit.sv
// csr_irq_trap_unit: machine-mode CSR file with fixed-priority interrupt/trap control
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   csr_addr/op/wdata         CSR access from execute (op: 0 none, 1 write, 2 set, 3 clear)
//   csr_rdata, csr_illegal    pre-update read value, unimplemented-address flag
//   irq_ext/timer/soft        level interrupt sources; irq_ack pulses the serviced ext channel
//   exc_valid/cause/tval      synchronous exception entry
//   pc_in, mret               PC saved on trap entry, mret retiring
//   trap_req/ack/vector       interrupt handshake toward the CPU and its target PC
//   mepc_out                  current mepc
module csr_irq_trap_unit #(
    parameter int          NUM_EXT     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    input  logic [NUM_EXT-1:0] irq_ext,
    input  logic               irq_timer,
    input  logic               irq_soft,
    output logic [NUM_EXT-1:0] irq_ack,
    input  logic               exc_valid,
    input  logic [4:0]         exc_cause,
    input  logic [31:0]        exc_tval,
    input  logic [31:0]        pc_in,
    input  logic               mret,
    output logic               trap_req,
    input  logic               trap_ack,
    output logic [31:0]        trap_vector,
    output logic [31:0]        mepc_out
);
    localparam logic [31:0] TVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
    localparam logic [31:0] MIE_MASK  = 32'h888 | (((32'd1 << (NUM_EXT - 1)) - 32'd1) << 16);

    // ch0 is the standard MEI bit; the rest live in the platform range from bit 16
    function automatic logic [4:0] ext_bit(input int i);
        return (i == 0) ? 5'd11 : 5'(15 + i);
    endfunction

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cause_q, cause_d, win;
    logic        pend_reg, st_mie, st_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [31:0] mip, live, mstatus, old_val, new_val;
    logic        live_any, legal, wen, int_entry;

    always_comb begin
        mip = '0;
        mip[3] = irq_soft;
        mip[7] = irq_timer;
        for (int i = 0; i < NUM_EXT; i++) mip[ext_bit(i)] = irq_ext[i];
    end

    assign live     = mip & mie_q & {32{st_mie}};
    assign live_any = |live;

    // later assignments win: ch0 > soft > timer > ch1..N-1 (lowest index first)
    always_comb begin
        win = 5'd0;
        for (int i = NUM_EXT - 1; i >= 1; i--) if (live[ext_bit(i)]) win = ext_bit(i);
        if (live[7]) win = 5'd7;
        if (live[3]) win = 5'd3;
        if (live[11]) win = 5'd11;
    end

    assign mstatus = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};

    always_comb begin
        legal   = 1'b1;
        old_val = '0;
        case (csr_addr)
            12'h300: old_val = mstatus;
            12'h301: old_val = 32'h4000_0100;
            12'h304: old_val = mie_q;
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h343: old_val = mtval_q;
            12'h344: old_val = mip;
            12'hF14: old_val = '0;
            default: legal = 1'b0;
        endcase
    end

    assign csr_rdata   = old_val;
    assign csr_illegal = (csr_op != 2'b00) && !legal;
    assign wen         = (csr_op != 2'b00) && legal;
    assign new_val     = (csr_op == 2'b01) ? csr_wdata :
                         (csr_op == 2'b10) ? (old_val | csr_wdata) : (old_val & ~csr_wdata);
    assign int_entry   = (state_q == REQ) && trap_ack && !exc_valid;

    // pend_reg may be stale by a cycle, so the live vector gates entry to REQ
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: if (pend_reg && live_any && !exc_valid) begin
                state_d = REQ;
                cause_d = win;
            end
            REQ:     state_d = exc_valid ? IDLE : trap_ack ? ACK : live[cause_q] ? REQ : IDLE;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cause_q  <= '0;
            pend_reg <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            pend_reg <= live_any;
        end
    end

    assign trap_req = (state_q == REQ);

    always_comb begin
        irq_ack = '0;
        for (int i = 0; i < NUM_EXT; i++) irq_ack[i] = (state_q == ACK) && (cause_q == ext_bit(i));
    end

    assign trap_vector = {mtvec_q[31:2], 2'b00} +
                         ((!exc_valid && mtvec_q[0]) ? {25'b0, cause_q, 2'b00} : 32'd0);
    assign mepc_out    = mepc_q;

    // trap entry beats mret, which beats a CSR write
    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET & TVEC_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (exc_valid || int_entry) begin
            mepc_q   <= pc_in & ~32'h3;
            mcause_q <= exc_valid ? {27'b0, exc_cause} : {1'b1, 26'b0, cause_q};
            mtval_q  <= exc_valid ? exc_tval : 32'd0;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
        end else if (mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (wen) begin
            case (csr_addr)
                12'h300: begin
                    st_mie  <= new_val[3];
                    st_mpie <= new_val[7];
                end
                12'h304: mie_q      <= new_val & MIE_MASK;
                12'h305: mtvec_q    <= new_val & TVEC_MASK;
                12'h340: mscratch_q <= new_val;
                12'h341: mepc_q     <= new_val & ~32'h3;
                12'h342: mcause_q   <= new_val;
                12'h343: mtval_q    <= new_val;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_irq_trap_unit.sv
// tb_csr_irq_trap_unit: scoreboard bench for csr_irq_trap_unit (vectored and direct-only instances)
module tb_csr_irq_trap_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0, exc_tval = '0, pc_in = '0;
    logic [3:0]  irq_ext = '0;
    logic        irq_timer = 1'b0, irq_soft = 1'b0, exc_valid = 1'b0, mret = 1'b0, trap_ack = 1'b0;
    logic [4:0]  exc_cause = '0;
    logic [31:0] csr_rdata, trap_vector, mepc_out, csr_rdata_v0, trap_vector_v0, mepc_out_v0;
    logic        csr_illegal, trap_req, csr_illegal_v0, trap_req_v0;
    logic [3:0]  irq_ack, irq_ack_v0;

    int          n_cmp = 0, n_err = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  ack_q[$];

    always #5 clk = ~clk;

    csr_irq_trap_unit #(.NUM_EXT(4), .MTVEC_RESET(32'h0), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .irq_ext(irq_ext), .irq_timer(irq_timer),
        .irq_soft(irq_soft), .irq_ack(irq_ack), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_tval(exc_tval), .pc_in(pc_in), .mret(mret), .trap_req(trap_req), .trap_ack(trap_ack),
        .trap_vector(trap_vector), .mepc_out(mepc_out)
    );

    csr_irq_trap_unit #(.NUM_EXT(4), .MTVEC_RESET(32'h0), .VECTORED_EN(1'b0)) dut_v0 (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata_v0), .csr_illegal(csr_illegal_v0), .irq_ext(irq_ext), .irq_timer(irq_timer),
        .irq_soft(irq_soft), .irq_ack(irq_ack_v0), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_tval(exc_tval), .pc_in(pc_in), .mret(mret), .trap_req(trap_req_v0), .trap_ack(trap_ack),
        .trap_vector(trap_vector_v0), .mepc_out(mepc_out_v0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_op = op;
        csr_addr = a;
        csr_wdata = d;
        cyc();
        csr_op = 2'b00;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] e);
        csr_op = 2'b00;
        csr_addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        check(tag, csr_rdata, exp_q.pop_front());
    endtask

    task automatic take(input logic [31:0] pc, input logic [3:0] ack);
        trap_ack = 1'b1;
        pc_in = pc;
        if (ack != 4'b0) ack_q.push_back(ack);
        cyc();
        trap_ack = 1'b0;
    endtask

    task automatic do_mret();
        mret = 1'b1;
        cyc();
        mret = 1'b0;
    endtask

    task automatic wait_req(input logic lvl);
        int n = 0;
        @(negedge clk);
        while (trap_req !== lvl && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", trap_req, lvl);
    endtask

    // every ack pulse must match an expectation queued when trap_ack was driven
    always @(negedge clk) begin
        if (irq_ack !== 4'b0) begin
            if (ack_q.size() == 0) check("ack_spur", irq_ack, 0);
            else check("irq_ack", irq_ack, ack_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_req", trap_req, 0);
        check("rst_ack", irq_ack, 0);
        rd("rst_mstatus", 12'h300, 32'h1800);
        rd("rst_mtvec", 12'h305, 32'h0);
        rd("rst_mie", 12'h304, 32'h0);
        rd("misa", 12'h301, 32'h4000_0100);

        csr(2'b01, 12'h304, 32'h800);
        csr(2'b01, 12'h300, 32'h8);
        irq_ext[0] = 1'b1;
        @(negedge clk); check("req_c0", trap_req, 0);
        @(negedge clk); check("req_c1", trap_req, 0);
        @(negedge clk); check("req_c2", trap_req, 1);
        check("tvec_direct", trap_vector, 32'h0);
        take(32'h100, 4'b0001);
        rd("ent_mepc", 12'h341, 32'h100);
        check("ack_cycle_req", trap_req, 0);
        check("mepc_out", mepc_out, 32'h100);
        rd("ent_mcause", 12'h342, 32'h8000_000B);
        rd("ent_mstatus", 12'h300, 32'h1880);
        rd("ent_mtval", 12'h343, 32'h0);
        irq_ext[0] = 1'b0;
        do_mret();
        rd("mret_mstatus", 12'h300, 32'h1888);

        csr(2'b01, 12'h305, 32'h1001);
        csr(2'b01, 12'h304, 32'h20080);
        irq_timer = 1'b1;
        irq_ext[2] = 1'b1;
        wait_req(1'b1);
        check("tvec_timer", trap_vector, 32'h101C);
        check("tvec_timer_v0", trap_vector_v0, 32'h1000);
        take(32'h200, 4'b0000);
        irq_timer = 1'b0;
        rd("timer_mcause", 12'h342, 32'h8000_0007);
        do_mret();
        wait_req(1'b1);
        check("tvec_ch2", trap_vector, 32'h1044);
        take(32'h204, 4'b0100);
        irq_ext[2] = 1'b0;
        rd("ch2_mcause", 12'h342, 32'h8000_0011);
        rd("ch2_mepc", 12'h341, 32'h204);
        do_mret();

        csr(2'b10, 12'h304, 32'h800);
        irq_ext[0] = 1'b1;
        wait_req(1'b1);
        csr(2'b11, 12'h300, 32'h8);
        wait_req(1'b0);
        rd("wd_mepc", 12'h341, 32'h204);
        rd("wd_mcause", 12'h342, 32'h8000_0011);
        rd("wd_mstatus", 12'h300, 32'h1880);
        irq_ext[0] = 1'b0;

        csr(2'b10, 12'h300, 32'h8);
        irq_ext[0] = 1'b1;
        wait_req(1'b1);
        exc_valid = 1'b1;
        exc_cause = 5'd2;
        exc_tval = 32'hDEAD;
        trap_ack = 1'b1;
        pc_in = 32'h300;
        #1;
        check("tvec_exc", trap_vector, 32'h1000);
        cyc();
        exc_valid = 1'b0;
        trap_ack = 1'b0;
        irq_ext[0] = 1'b0;
        rd("exc_mcause", 12'h342, 32'h2);
        check("exc_req", trap_req, 0);
        rd("exc_mtval", 12'h343, 32'hDEAD);
        rd("exc_mepc", 12'h341, 32'h300);
        rd("exc_mstatus", 12'h300, 32'h1880);

        csr(2'b01, 12'h300, 32'hFFFF_FFFF);
        rd("mask_mstatus", 12'h300, 32'h1888);
        csr(2'b01, 12'h304, 32'hFFFF_FFFF);
        rd("mask_mie", 12'h304, 32'h0007_0888);
        csr(2'b01, 12'h305, 32'hFFFF_FFFF);
        rd("mask_mtvec", 12'h305, 32'hFFFF_FFFD);
        check("mask_mtvec_v0", csr_rdata_v0, 32'hFFFF_FFFC);
        csr(2'b01, 12'h341, 32'hFFFF_FFFF);
        rd("mask_mepc", 12'h341, 32'hFFFF_FFFC);
        csr(2'b01, 12'h340, 32'h1234_5678);
        csr(2'b10, 12'h340, 32'h8000_0001);
        rd("scratch_set", 12'h340, 32'h9234_5679);
        csr(2'b11, 12'h340, 32'h1234_5678);
        rd("scratch_clr", 12'h340, 32'h8000_0001);
        csr(2'b01, 12'h301, 32'h0);
        rd("misa_ro", 12'h301, 32'h4000_0100);
        csr_op = 2'b01;
        csr_addr = 12'h7C0;
        #1;
        check("illegal", csr_illegal, 1);
        check("illegal_rdata", csr_rdata, 0);
        csr_addr = 12'h344;
        #1;
        check("mip_wr_legal", csr_illegal, 0);
        csr_op = 2'b00;
        csr_addr = 12'h7C0;
        #1;
        check("noop_legal", csr_illegal, 0);
        csr(2'b01, 12'h300, 32'h0);
        irq_soft = 1'b1;
        irq_ext[3] = 1'b1;
        rd("mip_live", 12'h344, 32'h0004_0008);
        irq_soft = 1'b0;
        irq_ext[3] = 1'b0;
        rd("mhartid", 12'hF14, 32'h0);

        csr(2'b01, 12'h300, 32'h8);
        irq_ext[1] = 1'b1;
        wait_req(1'b1);
        check("tvec_wrap", trap_vector, 32'h3C);
        rst = 1'b1;
        cyc();
        @(negedge clk);
        check("rst_mid_req", trap_req, 0);
        rst = 1'b0;
        irq_ext[1] = 1'b0;
        rd("rst2_mstatus", 12'h300, 32'h1800);
        rd("rst2_mie", 12'h304, 32'h0);
        rd("rst2_mtvec", 12'h305, 32'h0);
        rd("rst2_mepc", 12'h341, 32'h0);
        rd("rst2_mcause", 12'h342, 32'h0);
        rd("rst2_mscratch", 12'h340, 32'h0);
        check("rst2_req", trap_req, 0);

        repeat (2) cyc();
        check("ack_left", ack_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
